// File: rtl/uart_rx_nb_if.sv
// uart_rx_nb_if: serial line in, received word and strobes out, between the RX pin and the CPU port
interface uart_rx_nb_if #(parameter int n = 8);
  logic         rx;
  logic [n-1:0] data_out;
  logic         valid;
  logic         frame_err;
  logic         busy;
  modport master (output rx, input data_out, valid, frame_err, busy);
  modport slave (input rx, output data_out, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_nb.sv
// uart_rx_nb: start/n-data/stop serial receiver presenting each good word with a one-cycle valid strobe
module uart_rx_nb #(
  parameter int n = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input logic         clk,
  input logic         clr,
  uart_rx_nb_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(n);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MID = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(n - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t        state, state_n;
  logic [1:0]    sync;
  logic          rx_s;
  logic [TW-1:0] tick, tick_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [n-1:0]  shreg, shreg_n, dout, dout_n;
  logic          valid, valid_n, ferr, ferr_n;
  assign rx_s = sync[1];
  assign bus.data_out = dout;
  assign bus.valid = valid;
  assign bus.frame_err = ferr;
  assign bus.busy = state != IDLE;
  // two-flop synchroniser, reset to the idle-high line level
  always_ff @(posedge clk or posedge clr)
    if (clr) sync <= 2'b11;
    else sync <= {sync[0], bus.rx};
  // state, counters, shift register and registered strobes
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      tick <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      dout <= '0;
      valid <= 1'b0;
      ferr <= 1'b0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      bit_cnt <= bit_n;
      shreg <= shreg_n;
      dout <= dout_n;
      valid <= valid_n;
      ferr <= ferr_n;
    end
  // next state: mid-start check, mid-bit data samples, mid-stop framing check, break hold-off
  always_comb begin
    state_n = state;
    tick_n = tick + 1'b1;
    bit_n = bit_cnt;
    shreg_n = shreg;
    dout_n = dout;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START:
        if (tick == T_MID) begin
          tick_n = '0;
          bit_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (tick == T_LAST) begin
          tick_n = '0;
          shreg_n = {rx_s, shreg[n-1:1]};
          bit_n = bit_cnt + 1'b1;
          state_n = bit_cnt == B_LAST ? STOP : DATA;
        end
      STOP:
        if (tick == T_LAST) begin
          tick_n = '0;
          dout_n = rx_s ? shreg : dout;
          valid_n = rx_s;
          ferr_n = !rx_s;
          state_n = rx_s ? IDLE : BRK;
        end
      BRK: begin
        tick_n = '0;
        state_n = rx_s ? IDLE : BRK;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_nb.sv
// tb_uart_rx_nb: directed frames checked against an offset-based frame model plus literal expectations
module tb_uart_rx_nb;
  localparam int N = 8;
  localparam int CPB = 16;
  localparam int HMAX = 16384;
  logic clk = 0;
  logic clr = 1;
  uart_rx_nb_if #(.n(N)) bus();
  uart_rx_nb #(.n(N), .CLKS_PER_BIT(CPB)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // Model: r[k] is rx seen at edge k; decisions at edge k use r[k-2] (synchroniser).
  // A frame detected at edge s is checked at s+CPB/2, data bit i at s+CPB/2+CPB*(i+1),
  // stop at s+CPB/2+CPB*(N+1); the strobes show during the cycle after that edge.
  bit hist [HMAX];
  int k = 0;
  int s = 0;
  int mode = 0;
  logic [7:0] word = 0;
  logic [7:0] e_data = 0;
  logic e_valid = 0;
  logic e_ferr = 0;
  always @(posedge clk) begin
    int off;
    logic rs;
    if (clr) begin
      mode = 0;
      e_valid = 0;
      e_ferr = 0;
      e_data = 0;
      hist[k % HMAX] = 1'b1;
    end else begin
      rs = (k >= 2) ? hist[(k - 2) % HMAX] : 1'b1;
      hist[k % HMAX] = bus.rx;
      e_valid = 0;
      e_ferr = 0;
      off = k - s;
      if (mode == 0) begin
        if (!rs) begin mode = 1; s = k; end
      end else if (mode == 2) begin
        if (rs) mode = 0;
      end else if (off == CPB / 2) begin
        if (rs) mode = 0;
      end else if (off == CPB / 2 + CPB * (N + 1)) begin
        if (rs) begin e_valid = 1; e_data = word; mode = 0; end
        else begin e_ferr = 1; mode = 2; end
      end else if (off > CPB / 2 && (off - CPB / 2) % CPB == 0) begin
        word[(off - CPB / 2) / CPB - 1] = rs;
      end
    end
    k++;
  end
  always @(negedge clk)
    if (!clr) begin
      chk("cyc_valid", bus.valid, e_valid);
      chk("cyc_frame_err", bus.frame_err, e_ferr);
      chk("cyc_busy", bus.busy, mode != 0);
      chk("cyc_data", bus.data_out, e_data);
    end
  int nv = 0;
  int nf = 0;
  int last_v = 0;
  int prev_v = 0;
  logic [7:0] d_last = 0;
  logic [7:0] d_prev = 0;
  always @(negedge clk) begin
    if (bus.valid) begin
      nv++;
      prev_v = last_v;
      last_v = k;
      d_prev = d_last;
      d_last = bus.data_out;
    end
    if (bus.frame_err) nf++;
  end
  task automatic bitp(input logic v);
    bus.rx = v;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic frame(input logic [7:0] d, input logic stop);
    bitp(1'b0);
    for (int i = 0; i < N; i++) bitp(d[i]);
    bitp(stop);
  endtask
  task automatic idle(input int c);
    bus.rx = 1'b1;
    repeat (c) @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int v0, f0;
    bus.rx = 1'b1;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_data", bus.data_out, 0);
    idle(4);
    v0 = nv; f0 = nf;
    frame(8'hA5, 1'b1);
    idle(20);
    chk("t1_valid_count", nv - v0, 1);
    chk("t1_data", bus.data_out, 8'hA5);
    chk("t1_model_data", e_data, 8'hA5);
    chk("t1_frame_err_count", nf - f0, 0);
    chk("t1_busy", bus.busy, 0);
    v0 = nv; f0 = nf;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_busy", bus.busy, 0);
    idle(10);
    chk("t2_valid_count", nv - v0, 0);
    chk("t2_frame_err_count", nf - f0, 0);
    frame(8'h3C, 1'b1);
    idle(20);
    chk("t3_first_data", bus.data_out, 8'h3C);
    v0 = nv; f0 = nf;
    frame(8'h81, 1'b0);
    repeat (40) @(negedge clk);
    chk("t3_busy_held", bus.busy, 1);
    chk("t3_frame_err_count", nf - f0, 1);
    chk("t3_valid_count", nv - v0, 0);
    chk("t3_data_kept", bus.data_out, 8'h3C);
    chk("t3_model_data", e_data, 8'h3C);
    idle(6);
    chk("t3_busy_release", bus.busy, 0);
    v0 = nv; f0 = nf;
    bitp(1'b0);
    for (int i = 0; i < 4; i++) bitp(1'b1);
    bus.rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    chk("t4_busy_before", bus.busy, 1);
    #2 clr = 1'b1;
    #1;
    chk("t4_busy_clr", bus.busy, 0);
    chk("t4_data_clr", bus.data_out, 0);
    chk("t4_valid_clr", bus.valid, 0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("t4_busy_after", bus.busy, 0);
    idle(CPB * 6);
    chk("t4_abort_valid", nv - v0, 0);
    chk("t4_abort_frame_err", nf - f0, 0);
    frame(8'h5A, 1'b1);
    idle(20);
    chk("t4_next_data", bus.data_out, 8'h5A);
    chk("t4_next_valid", nv - v0, 1);
    v0 = nv; f0 = nf;
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    idle(20);
    chk("t5_valid_count", nv - v0, 2);
    chk("t5_first_word", d_prev, 8'h00);
    chk("t5_second_word", d_last, 8'hFF);
    chk("t5_spacing", last_v - prev_v, 160);
    chk("t5_frame_err_count", nf - f0, 0);
    chk("t5_busy", bus.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
